// File: rtl/approx_adder_pipe.sv
// Elastic, STAGES-deep carry-segmented adder with per-transaction lower-part-OR approximation.
// Define APPROX_ERR_MON_EN to build the exact-sum shadow path and the err_cnt/err_max monitor.
module approx_adder_pipe #(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 4,
  parameter int APPROX_LSBS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  input  logic             err_clr,
  output logic [31:0]      err_cnt,
  output logic [WIDTH:0]   err_max
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_stages
    $error("approx_adder_pipe: WIDTH must be a multiple of STAGES");
  end
  if (APPROX_LSBS < 0 || APPROX_LSBS > WIDTH) begin : g_bad_lsbs
    $error("approx_adder_pipe: APPROX_LSBS must lie in 0..WIDTH");
  end

  // One in-flight transaction: operands, partial sum, carry into the next segment.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             ap;
`ifdef APPROX_ERR_MON_EN
    logic [WIDTH-1:0] ex;
    logic             ex_c;
`endif
  } tok_t;

  // Approximated bits ignore their carry-in and emit a AND b, so bit L sees a[L-1] & b[L-1].
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                           input logic cin, input logic approx, input int base);
    logic [SEG-1:0] s;
    logic           c;
    // NOTE: blocking '=' is deliberate here: c must ripple bit to bit within one evaluation.
    s = '0;
    c = cin;
    for (int i = 0; i < SEG; i++) begin
      if (approx && (base + i) < APPROX_LSBS) begin
        s[i] = a[i] | b[i];
        c    = a[i] & b[i];
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return {c, s};
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              rdy;
  tok_t              tok_q [STAGES];
  tok_t              tok_d [STAGES];
  tok_t              src   [STAGES];

  // Ready ripples from the output back to the input: a stage moves if the one after is empty or moving.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    adv  = '0;
    load = '0;
    rdy  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = v_q[k] & rdy;
      rdy    = ~v_q[k] | rdy;
    end
    in_ready = rdy;
    load[0]  = in_valid & rdy;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  always_comb begin
    src[0]    = '0;
    src[0].a  = in_a;
    src[0].b  = in_b;
    src[0].ap = approx_en;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = tok_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      tok_d[k] = src[k];
      {tok_d[k].c, tok_d[k].sum[k*SEG +: SEG]} =
        seg_add(src[k].a[k*SEG +: SEG], src[k].b[k*SEG +: SEG], src[k].c, src[k].ap, k * SEG);
`ifdef APPROX_ERR_MON_EN
      {tok_d[k].ex_c, tok_d[k].ex[k*SEG +: SEG]} =
        seg_add(src[k].a[k*SEG +: SEG], src[k].b[k*SEG +: SEG], src[k].ex_c, 1'b0, k * SEG);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      // NOTE: token data is reset as well as the valids so out_sum reads 0 straight out of reset.
      for (int k = 0; k < STAGES; k++) begin
        tok_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k]   <= 1'b1;
          tok_q[k] <= tok_d[k];
        end else if (adv[k]) begin
          v_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = {tok_q[STAGES-1].c, tok_q[STAGES-1].sum};

  logic unused_tail;
  assign unused_tail = ^{tok_q[STAGES-1].a, tok_q[STAGES-1].b, tok_q[STAGES-1].ap};

`ifdef APPROX_ERR_MON_EN
  logic [WIDTH:0] exact_sum;
  logic [WIDTH:0] diff;
  logic           out_fire;
  logic [31:0]    err_cnt_q, err_cnt_d;
  logic [WIDTH:0] err_max_q, err_max_d;

  assign exact_sum = {tok_q[STAGES-1].ex_c, tok_q[STAGES-1].ex};
  assign out_fire  = out_valid & out_ready;
  assign diff      = (out_sum > exact_sum) ? (out_sum - exact_sum) : (exact_sum - out_sum);

  // Clear has priority over a coincident update; the count saturates at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (err_clr) begin
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (out_fire && diff != '0) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
      if (diff > err_max_q) err_max_d = diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_max_q <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`else
  logic unused_clr;
  assign unused_clr = err_clr;
  assign err_cnt    = '0;
  assign err_max    = '0;
`endif

endmodule
